// File: rtl/reg_wb_pkg.sv
// Shared types for the register write-back controller.
// Default widths, FSM state and the pending-write entry.
package reg_wb_pkg;

  localparam int WB_DATA_W = 13;
  localparam int WB_ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    STALL
  } wb_state_e;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of pending writes; every slot is visible
// for the bypass search and the tail slot can be rewritten.
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  wb_entry_t i_wr,
  input  logic      i_pop,
  input  logic      i_ovr,
  output wb_entry_t o_head,
  output wb_entry_t o_mem [DEPTH],
  output logic [AW:0] o_rd_ptr,
  output logic [AW:0] o_count,
  output logic      o_full,
  output logic      o_empty
);

  logic [AW:0]   r_wr;
  logic [AW:0]   r_rd;
  wb_entry_t     r_mem [DEPTH];
  logic [AW-1:0] w_tail_idx;

  assign w_tail_idx = r_wr[AW-1:0] - AW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  // Storage needs no reset: slots are only read while counted.
  always_ff @(posedge clk) begin
    if (i_push)
      r_mem[r_wr[AW-1:0]] <= i_wr;
    else if (i_ovr)
      r_mem[w_tail_idx].data <= i_wr.data;
  end

  assign o_head   = r_mem[r_rd[AW-1:0]];
  assign o_mem    = r_mem;
  assign o_rd_ptr = r_rd;
  assign o_count  = r_wr - r_rd;
  assign o_empty  = (r_wr == r_rd);
  assign o_full   = (r_wr[AW] != r_rd[AW]) &&
                    (r_wr[AW-1:0] == r_rd[AW-1:0]);

endmodule

// File: rtl/reg_wb_ctrl.sv
// Write-back controller driving the register bank (chosen/w_en/w_data).
// Optional tail coalescing is enabled with WB_COALESCE_EN.
module reg_wb_ctrl
  import reg_wb_pkg::*;
#(
  parameter int DATA_W   = WB_DATA_W,
  parameter int NUM_REGS = 6,
  parameter int ADDR_W   = WB_ADDR_W,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_data,
  input  logic                wb_stall,
  output logic [NUM_REGS-1:0] chosen,
  output logic                w_en,
  output logic [DATA_W-1:0]   w_data,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_hit,
  output logic [DATA_W-1:0]   rd_data,
  output logic                busy,
  output logic                err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LP_NREGS = (ADDR_W+1)'(NUM_REGS);

  wb_state_e r_state;
  wb_state_e w_state_nxt;

  logic                r_wen;
  logic [NUM_REGS-1:0] r_chosen;
  logic [DATA_W-1:0]   r_wdata;
  logic [ADDR_W-1:0]   r_waddr;
  logic                r_err;

  logic        w_full;
  logic        w_empty;
  logic [AW:0] w_count;
  logic [AW:0] w_rd_ptr;
  wb_entry_t   w_head;
  wb_entry_t   w_mem [DEPTH];
  wb_entry_t   w_wr;

  logic w_in_range;
  logic w_push;
  logic w_pop;
  logic w_coal;
  logic w_alloc;
  logic w_last;
  logic w_hit;
  logic [DATA_W-1:0] w_rdata;

  assign w_in_range = ({1'b0, req_addr} < LP_NREGS);

`ifdef WB_COALESCE_EN
  logic [AW-1:0] w_tail_idx;
  logic          w_tail_hit;

  assign w_tail_idx = w_rd_ptr[AW-1:0] + w_count[AW-1:0] - AW'(1);
  assign w_tail_hit = !w_empty &&
                      (w_mem[w_tail_idx].addr == req_addr);
  assign req_ready  = !w_full | w_tail_hit;
  // A single-entry FIFO that pops this edge has no tail to merge into.
  assign w_coal = w_push & w_in_range & w_tail_hit &
                  !(w_pop & (w_count == (AW+1)'(1)));
`else
  assign req_ready = !w_full;
  assign w_coal    = 1'b0;
`endif

  assign w_push  = req_valid & req_ready;
  assign w_pop   = !w_empty & !wb_stall;
  assign w_alloc = w_push & w_in_range & !w_coal;
  assign w_last  = w_pop & (w_count == (AW+1)'(1)) & !w_alloc;
  assign w_wr    = '{addr: req_addr, data: req_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_alloc),
    .i_wr     (w_wr),
    .i_pop    (w_pop),
    .i_ovr    (w_coal),
    .o_head   (w_head),
    .o_mem    (w_mem),
    .o_rd_ptr (w_rd_ptr),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_alloc) w_state_nxt = DRAIN;
      DRAIN: begin
        if (w_last)        w_state_nxt = IDLE;
        else if (wb_stall) w_state_nxt = STALL;
      end
      STALL: begin
        if (!wb_stall)
          w_state_nxt = w_last ? IDLE : DRAIN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen    <= 1'b0;
      r_chosen <= '0;
      r_wdata  <= '0;
      r_waddr  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= r_err | (w_push & !w_in_range);
      if (w_pop) begin
        r_wen    <= 1'b1;
        r_chosen <= NUM_REGS'(1) << w_head.addr;
        r_wdata  <= w_head.data;
        r_waddr  <= w_head.addr;
      end else begin
        r_wen    <= 1'b0;
        r_chosen <= '0;
      end
    end
  end

  // Oldest first so that later (newer) matches overwrite.
  always_comb begin
    w_hit   = 1'b0;
    w_rdata = '0;
    if (r_wen && (r_waddr == rd_addr)) begin
      w_hit   = 1'b1;
      w_rdata = r_wdata;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (((AW+1)'(i) < w_count) &&
          (w_mem[AW'(w_rd_ptr[AW-1:0] + AW'(i))].addr
           == rd_addr)) begin
        w_hit   = 1'b1;
        w_rdata =
          w_mem[AW'(w_rd_ptr[AW-1:0] + AW'(i))].data;
      end
    end
  end

  assign chosen  = r_chosen;
  assign w_en    = r_wen;
  assign w_data  = r_wdata;
  assign rd_hit  = w_hit;
  assign rd_data = w_rdata;
  assign busy    = (r_state != IDLE) | r_wen;
  assign err     = r_err;

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Bench for reg_wb_ctrl: directed table plus random traffic
// checked against a queue-based model (WB_COALESCE_EN aware).
module tb_reg_wb_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_addr;
  logic [12:0] req_data;
  logic        wb_stall;
  logic [5:0]  chosen;
  logic        w_en;
  logic [12:0] w_data;
  logic [2:0]  rd_addr;
  logic        rd_hit;
  logic [12:0] rd_data;
  logic        busy;
  logic        err;

  reg_wb_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wb_stall  (wb_stall),
    .chosen    (chosen),
    .w_en      (w_en),
    .w_data    (w_data),
    .rd_addr   (rd_addr),
    .rd_hit    (rd_hit),
    .rd_data   (rd_data),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        chk;
    logic        rs;
    logic        v;
    logic [2:0]  a;
    logic [12:0] d;
    logic        st;
    logic [2:0]  ra;
    logic        rdy;
    logic        wen;
    logic [5:0]  ch;
    logic [12:0] wd;
    logic        bsy;
    logic        hit;
    logic [12:0] rdd;
    logic        er;
  } vec_t;

  typedef struct {
    logic [2:0]  a;
    logic [12:0] d;
  } ent_t;

  vec_t tbl[$];
  ent_t q[$];
  bit          m_oen;
  logic [2:0]  m_oa;
  logic [12:0] m_od;
  bit          m_err;

  int nvec;
  int nmis;

  function automatic vec_t mk(
    logic chk, logic rs, logic v, logic [2:0] a,
    logic [12:0] d, logic st, logic [2:0] ra,
    logic rdy, logic wen, logic [5:0] ch,
    logic [12:0] wd, logic bsy, logic hit,
    logic [12:0] rdd, logic er);
    vec_t r;
    r.chk = chk; r.rs = rs; r.v = v; r.a = a;
    r.d = d; r.st = st; r.ra = ra; r.rdy = rdy;
    r.wen = wen; r.ch = ch; r.wd = wd; r.bsy = bsy;
    r.hit = hit; r.rdd = rdd; r.er = er;
    return r;
  endfunction

  task automatic cmp(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s @%0t: got %0h expected %0h",
               nm, $time, act, exp);
    end
  endtask

  function automatic bit m_ready();
    int n;
    n = q.size();
    if (n < 4) return 1'b1;
`ifdef WB_COALESCE_EN
    if (q[n-1].a == req_addr) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic m_check();
    bit          hit;
    logic [12:0] rd;
    logic [5:0]  ch;
    hit = 1'b0;
    rd  = '0;
    if (m_oen && m_oa == rd_addr) begin
      hit = 1'b1;
      rd  = m_od;
    end
    foreach (q[i]) begin
      if (q[i].a == rd_addr) begin
        hit = 1'b1;
        rd  = q[i].d;
      end
    end
    ch = m_oen ? 6'(1 << m_oa) : 6'd0;
    cmp("rdy", 16'(req_ready), 16'(m_ready()));
    cmp("w_en", 16'(w_en), 16'(m_oen));
    cmp("chosen", 16'(chosen), 16'(ch));
    cmp("w_data", 16'(w_data), 16'(m_od));
    cmp("busy", 16'(busy), 16'(q.size() != 0 || m_oen));
    cmp("rd_hit", 16'(rd_hit), 16'(hit));
    cmp("rd_data", 16'(rd_data), 16'(rd));
    cmp("err", 16'(err), 16'(m_err));
  endtask

  task automatic m_update();
    bit   push;
    bit   pop;
    bit   inr;
    bit   coal;
    int   n;
    ent_t h;
    ent_t t;
    if (rst) begin
      q.delete();
      m_oen = 1'b0;
      m_oa  = '0;
      m_od  = '0;
      m_err = 1'b0;
    end else begin
      n    = q.size();
      push = req_valid && m_ready();
      inr  = (req_addr < 3'd6);
      pop  = (n > 0) && !wb_stall;
      coal = 1'b0;
      if (push && !inr) m_err = 1'b1;
`ifdef WB_COALESCE_EN
      if (push && inr && n > 0 && q[n-1].a == req_addr &&
          !(pop && n == 1))
        coal = 1'b1;
`endif
      if (pop) begin
        h     = q.pop_front();
        m_oen = 1'b1;
        m_oa  = h.a;
        m_od  = h.d;
      end else begin
        m_oen = 1'b0;
      end
      if (coal) begin
        t   = q[q.size()-1];
        t.d = req_data;
        q[q.size()-1] = t;
      end else if (push && inr) begin
        t.a = req_addr;
        t.d = req_data;
        q.push_back(t);
      end
    end
  endtask

  task automatic step(input vec_t v, input bit mdl);
    @(negedge clk);
    rst       = v.rs;
    req_valid = v.v;
    req_addr  = v.a;
    req_data  = v.d;
    wb_stall  = v.st;
    rd_addr   = v.ra;
    #1;
    if (mdl) begin
      m_check();
    end else if (v.chk) begin
      cmp("t_rdy", 16'(req_ready), 16'(v.rdy));
      cmp("t_w_en", 16'(w_en), 16'(v.wen));
      cmp("t_chosen", 16'(chosen), 16'(v.ch));
      cmp("t_w_data", 16'(w_data), 16'(v.wd));
      cmp("t_busy", 16'(busy), 16'(v.bsy));
      cmp("t_rd_hit", 16'(rd_hit), 16'(v.hit));
      cmp("t_rd_data", 16'(rd_data), 16'(v.rdd));
      cmp("t_err", 16'(err), 16'(v.er));
    end
    @(posedge clk);
    m_update();
  endtask

  initial begin
    vec_t rv;
    nvec      = 0;
    nmis      = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    wb_stall  = 1'b0;
    rd_addr   = '0;
    m_oen     = 1'b0;
    m_oa      = '0;
    m_od      = '0;
    m_err     = 1'b0;

    // chk rs v a d st ra | rdy wen ch wd busy hit rdd err
    // reset
    tbl.push_back(mk(0,1,0,0,13'h0,0,0, 1,0,6'h00,13'h0,0,0,13'h0,0));
    tbl.push_back(mk(1,1,0,0,13'h0,0,0, 1,0,6'h00,13'h0,0,0,13'h0,0));
    // single write
    tbl.push_back(mk(1,0,1,2,13'h1ABC,0,2, 1,0,6'h00,13'h0,0,0,13'h0,0));
    tbl.push_back(mk(1,0,0,0,13'h0,0,2, 1,0,6'h00,13'h0,1,1,13'h1ABC,0));
    tbl.push_back(mk(1,0,0,0,13'h0,0,2, 1,1,6'h04,13'h1ABC,1,1,13'h1ABC,0));
    tbl.push_back(mk(1,0,0,0,13'h0,0,2, 1,0,6'h00,13'h1ABC,0,0,13'h0,0));
    // fill while stalled, then drain
    tbl.push_back(mk(1,0,1,0,13'h10,1,0, 1,0,6'h00,13'h1ABC,0,0,13'h0,0));
    tbl.push_back(mk(1,0,1,1,13'h11,1,0, 1,0,6'h00,13'h1ABC,1,1,13'h10,0));
    tbl.push_back(mk(1,0,1,2,13'h12,1,0, 1,0,6'h00,13'h1ABC,1,1,13'h10,0));
    tbl.push_back(mk(1,0,1,3,13'h13,1,0, 1,0,6'h00,13'h1ABC,1,1,13'h10,0));
    tbl.push_back(mk(1,0,1,4,13'h14,1,3, 0,0,6'h00,13'h1ABC,1,1,13'h13,0));
    tbl.push_back(mk(1,0,1,4,13'h14,1,3, 0,0,6'h00,13'h1ABC,1,1,13'h13,0));
    tbl.push_back(mk(1,0,1,4,13'h14,0,3, 0,0,6'h00,13'h1ABC,1,1,13'h13,0));
    tbl.push_back(mk(1,0,1,4,13'h14,0,3, 1,1,6'h01,13'h10,1,1,13'h13,0));
    tbl.push_back(mk(1,0,0,0,13'h0,0,3, 1,1,6'h02,13'h11,1,1,13'h13,0));
    tbl.push_back(mk(1,0,0,0,13'h0,0,3, 1,1,6'h04,13'h12,1,1,13'h13,0));
    tbl.push_back(mk(1,0,0,0,13'h0,0,3, 1,1,6'h08,13'h13,1,1,13'h13,0));
    tbl.push_back(mk(1,0,0,0,13'h0,0,3, 1,1,6'h10,13'h14,1,0,13'h0,0));
    tbl.push_back(mk(1,0,0,0,13'h0,0,3, 1,0,6'h00,13'h14,0,0,13'h0,0));
    // bypass, newest wins
    tbl.push_back(mk(1,0,1,1,13'h5,1,1, 1,0,6'h00,13'h14,0,0,13'h0,0));
    tbl.push_back(mk(1,0,1,1,13'h7,1,1, 1,0,6'h00,13'h14,1,1,13'h5,0));
    tbl.push_back(mk(1,0,0,0,13'h0,1,1, 1,0,6'h00,13'h14,1,1,13'h7,0));
    tbl.push_back(mk(1,0,0,0,13'h0,1,3, 1,0,6'h00,13'h14,1,0,13'h0,0));
    tbl.push_back(mk(1,1,0,0,13'h0,1,1, 1,0,6'h00,13'h14,1,1,13'h7,0));
    tbl.push_back(mk(1,0,0,0,13'h0,0,1, 1,0,6'h00,13'h0,0,0,13'h0,0));
    // out-of-range address
    tbl.push_back(mk(1,0,1,7,13'h1FFF,0,7, 1,0,6'h00,13'h0,0,0,13'h0,0));
    tbl.push_back(mk(1,0,0,0,13'h0,0,7, 1,0,6'h00,13'h0,0,0,13'h0,1));
    tbl.push_back(mk(1,0,0,0,13'h0,0,7, 1,0,6'h00,13'h0,0,0,13'h0,1));
    tbl.push_back(mk(1,1,0,0,13'h0,0,7, 1,0,6'h00,13'h0,0,0,13'h0,1));
    tbl.push_back(mk(1,0,0,0,13'h0,0,7, 1,0,6'h00,13'h0,0,0,13'h0,0));
    // reset while draining
    tbl.push_back(mk(1,0,1,0,13'h21,1,5, 1,0,6'h00,13'h0,0,0,13'h0,0));
    tbl.push_back(mk(1,0,1,5,13'h25,1,5, 1,0,6'h00,13'h0,1,0,13'h0,0));
    tbl.push_back(mk(1,0,1,3,13'h23,1,5, 1,0,6'h00,13'h0,1,1,13'h25,0));
    tbl.push_back(mk(1,0,0,0,13'h0,0,5, 1,0,6'h00,13'h0,1,1,13'h25,0));
    tbl.push_back(mk(1,1,0,0,13'h0,0,5, 1,1,6'h01,13'h21,1,1,13'h25,0));
    tbl.push_back(mk(1,0,0,0,13'h0,0,5, 1,0,6'h00,13'h0,0,0,13'h0,0));
    tbl.push_back(mk(1,0,0,0,13'h0,0,5, 1,0,6'h00,13'h0,0,0,13'h0,0));
`ifdef WB_COALESCE_EN
    // two writes to addr 4 merge into one bank write
    tbl.push_back(mk(1,0,1,4,13'h31,1,4, 1,0,6'h00,13'h0,0,0,13'h0,0));
    tbl.push_back(mk(1,0,1,4,13'h32,1,4, 1,0,6'h00,13'h0,1,1,13'h31,0));
    tbl.push_back(mk(1,0,0,0,13'h0,0,4, 1,0,6'h00,13'h0,1,1,13'h32,0));
    tbl.push_back(mk(1,0,0,0,13'h0,0,4, 1,1,6'h10,13'h32,1,1,13'h32,0));
    tbl.push_back(mk(1,0,0,0,13'h0,0,4, 1,0,6'h00,13'h32,0,0,13'h0,0));
`endif

    foreach (tbl[i]) step(tbl[i], 1'b0);

    rv = mk(1,1,0,0,13'h0,0,0, 0,0,6'h00,13'h0,0,0,13'h0,0);
    step(rv, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      rv.rs = ($urandom_range(0, 149) == 0);
      rv.v  = ($urandom_range(0, 2) != 0);
      rv.a  = ($urandom_range(0, 29) == 0) ?
              3'($urandom_range(6, 7)) :
              3'($urandom_range(0, 5));
      rv.d  = 13'($urandom);
      rv.st = ($urandom_range(0, 9) < 4);
      rv.ra = 3'($urandom_range(0, 7));
      step(rv, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule

// File: doc/reg_wb_ctrl.md
Name: reg_wb_ctrl

Overview:
- Write-back controller: the initiator side of the register write interface (chosen / w_en / w_data) that drives the team's 13-bit register bank.
- Accepts write requests over a valid/ready handshake and buffers them in a small FIFO.
- Drains at most one write per cycle, decoding the target address to a one-hot chosen vector.
- Provides a read-bypass lookup so consumers see pending data before it lands in the bank.

Parameters:
- DATA_W, 13: register data width; matches the bank registers.
- NUM_REGS, 6: number of registers in the bank; width of chosen.
- ADDR_W, 3: request/read address width; must satisfy 2**ADDR_W >= NUM_REGS.
- DEPTH, 4: pending-write FIFO entries (power of two).

Ports:
- clk  input  1  clock; one clock domain.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  write request valid.
- req_ready  output  1  controller can accept a request this cycle.
- req_addr  input  ADDR_W  target register index.
- req_data  input  DATA_W  write data.
- wb_stall  input  1  when high, no FIFO entry is issued to the bank.
- chosen  output  NUM_REGS  one-hot register select; all-zero when w_en=0.
- w_en  output  1  bank write enable.
- w_data  output  DATA_W  bank write data.
- rd_addr  input  ADDR_W  bypass lookup address.
- rd_hit  output  1  a pending write to rd_addr exists.
- rd_data  output  DATA_W  newest pending data for rd_addr; 0 when rd_hit=0.
- busy  output  1  FIFO non-empty or w_en high.
- err  output  1  sticky error: an out-of-range address was accepted.

Behaviour:
- Reset (synchronous): FIFO emptied, state IDLE. Outputs: chosen=0, w_en=0, w_data=0, err=0, busy=0, rd_hit=0, rd_data=0, req_ready=1.
- rst asserted mid-operation discards all pending entries. w_en=0 on the following cycle and no further bank writes occur.
- Handshake:
  - req_ready = !full. A push occurs on an edge where req_valid & req_ready.
  - When full, there is no same-cycle pass-through, even if a pop happens on that edge.
  - req_valid with req_ready=0 is not an error; the requester holds the request.
- Address check: a push with req_addr >= NUM_REGS is accepted but not stored, and sets err=1. err stays set until rst.
- Pop: occurs on an edge where FIFO is non-empty and wb_stall=0. Output registers then load:
  - w_en <= 1
  - chosen <= 1 << head.addr
  - w_data <= head.data
- Otherwise w_en <= 0 and chosen <= 0; w_data holds its last value.
- Latency: a request pushed at edge N into an empty FIFO with wb_stall=0 drives w_en=1 during cycle N+1. The bank commits it at edge N+2.
- Throughput: one write per cycle. Order is strictly FIFO.
- Simultaneous push and pop on the same edge is legal at any occupancy below full; occupancy is unchanged.
- FSM states:
  - IDLE: empty.
  - DRAIN: non-empty and wb_stall=0.
  - STALL: non-empty and wb_stall=1.
- FSM transitions:
  - IDLE->DRAIN on push.
  - DRAIN->STALL when wb_stall rises.
  - STALL->DRAIN when wb_stall falls.
  - DRAIN->IDLE when the last entry pops with no push on the same edge.
- busy = (state != IDLE) | w_en.
- Bypass (combinational from rd_addr and current state):
  - Searches all FIFO entries plus the output stage when w_en=1.
  - The newest match wins: FIFO tail first, then toward head, then the output stage.
- Pointer wrap: pointers carry an extra MSB; full/empty are decided by comparing that MSB.

Optional Feature:
- Macro WB_COALESCE_EN.
- Defined: a push whose address equals the FIFO tail entry's address overwrites that entry's data instead of allocating a new one. This applies only if the tail entry is not being popped on the same edge. Coalescing is allowed when full, so req_ready = !full | (req_addr == tail.addr).
- Undefined: every valid push allocates a new entry; req_ready = !full.

Decomposition:
- Shared package reg_wb_pkg holds:
  - DATA_W and ADDR_W defaults
  - the FSM state enum (IDLE, DRAIN, STALL)
  - the wb_entry_t struct {addr, data}
- Sub-module wb_fifo: parameterised synchronous FIFO of wb_entry_t. Exposes all entries for the bypass search plus tail-overwrite for coalescing.

Test Plan:
- Reset: assert rst for 2 cycles -> req_ready=1, w_en=0, chosen=0, busy=0, err=0, rd_hit=0.
- Single write: push addr=2, data=0x1ABC at edge N, wb_stall=0 -> cycle N+1: w_en=1, chosen=6'b000100, w_data=0x1ABC. Cycle N+2: w_en=0, busy=0.
- Full/stall: wb_stall=1, push addrs 0..3 (data 0x0010..0x0013) -> req_ready=0 after 4th push, 5th request held. Release stall -> 4 consecutive w_en pulses in order 0..3, req_ready=1 after first pop.
- Bypass: stall, push addr1=0x0005 then addr1=0x0007 -> rd_addr=1 gives rd_hit=1, rd_data=0x0007. rd_addr=3 gives rd_hit=0, rd_data=0.
- Error: push addr=7 -> err=1 next cycle and stays 1. No w_en for that request. rst clears err.
- Reset mid-drain: 3 entries pending, wb_stall=0, assert rst -> w_en=0 the next cycle, busy=0, no further writes. With WB_COALESCE_EN: two pushes to addr4 while stalled -> single w_en pulse carrying the second data.
